// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// and data-access requesters. One access is in flight at a time. Contention
// alternates between the two sides, and a watchdog aborts accesses that the
// memory never completes, flagging them with bus_err.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15   // 0 disables the watchdog
) (
  input  logic              clk,
  input  logic              reset,      // synchronous, active-low

  // Instruction-fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,

  // Data-access requester
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,

  // Memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Which side received the most recent grant; contention goes to the other.
  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

  // The counter only needs to hold values up to TIMEOUT-1.
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q;
  grant_t            last_grant_q;
  logic [CNT_W-1:0]  wd_cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              if_ack_q;
  logic              d_ack_q;
  logic              bus_err_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic fetch_pend;
  logic data_pend;
  logic grant_data_d;
  logic wd_expire;

  // Arbitration decision for this cycle's requests (used only in IDLE).
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    fetch_pend   = if_req;
    data_pend    = d_read | d_write;
    grant_data_d = 1'b0;
    if (data_pend && (!fetch_pend || (last_grant_q == GRANT_FETCH))) begin
      grant_data_d = 1'b1;
    end
  end

  // Watchdog fires on the BUSY cycle in which the counter would reach TIMEOUT.
  assign wd_expire = (TIMEOUT != 0) && (wd_cnt_q == CNT_LAST);

  // Main FSM; all strobes, acks and read data are registered here.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_FETCH;
      wd_cnt_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      bus_err_q    <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      // Acks and bus_err are single-cycle pulses unless set below.
      if_ack_q  <= 1'b0;
      d_ack_q   <= 1'b0;
      bus_err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (fetch_pend || data_pend) begin
            wd_cnt_q <= '0;
            if (grant_data_d) begin
              // A simultaneous read and write is treated as a write.
              mem_addr_q   <= d_addr;
              mem_wdata_q  <= d_wdata;
              mem_write_q  <= d_write;
              mem_read_q   <= ~d_write;
              last_grant_q <= GRANT_DATA;
              state_q      <= BUSY_D;
            end else begin
              mem_addr_q   <= if_addr;
              mem_read_q   <= 1'b1;
              mem_write_q  <= 1'b0;
              last_grant_q <= GRANT_FETCH;
              state_q      <= BUSY_F;
            end
          end
        end

        BUSY_F, BUSY_D: begin
          if (mem_ready) begin
            // Normal completion; wins over a watchdog expiring this cycle.
            if (state_q == BUSY_F) begin
              if_rdata_q <= mem_rdata;
              if_ack_q   <= 1'b1;
            end else begin
              if (mem_read_q) begin
                d_rdata_q <= mem_rdata;
              end
              d_ack_q <= 1'b1;
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state_q     <= DONE;
          end else if (wd_expire) begin
            // Abort: acknowledge with bus_err and zero read data.
            if (state_q == BUSY_F) begin
              if_rdata_q <= '0;
              if_ack_q   <= 1'b1;
            end else begin
              if (mem_read_q) begin
                d_rdata_q <= '0;
              end
              d_ack_q <= 1'b1;
            end
            bus_err_q   <= 1'b1;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state_q     <= DONE;
          end else if (TIMEOUT != 0) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end

        DONE: begin
          // Ack cycle; requesters drop or change their request now.
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign bus_err   = bus_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed test of mem_arbiter with hand-computed expectations.
// Inputs are driven and outputs sampled 1 time unit after each rising edge;
// "cycle n" means the clock period that follows rising edge n.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 15;

  logic              clk;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              bus_err;

  int total;
  int bad;

  mem_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .d_read   (d_read),
    .d_write  (d_write),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .bus_err  (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".mem_read"},  mem_read,  1'b0);
    check({tag, ".mem_write"}, mem_write, 1'b0);
    check({tag, ".if_ack"},    if_ack,    1'b0);
    check({tag, ".d_ack"},     d_ack,     1'b0);
    check({tag, ".bus_err"},   bus_err,   1'b0);
    check({tag, ".mem_addr"},  mem_addr,  32'h0);
    check({tag, ".mem_wdata"}, mem_wdata, 32'h0);
    check({tag, ".if_rdata"},  if_rdata,  32'h0);
    check({tag, ".d_rdata"},   d_rdata,   32'h0);
  endtask

  logic [DATA_W-1:0] exp_if_rdata;
  logic [DATA_W-1:0] exp_d_rdata;

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;

    // ---------------- reset state ----------------
    step();
    step();
    check_all_zero("reset");

    // ---------------- fetch only, zero-wait ----------------
    reset   = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h40;                          // cycle 0
    check("f.c0.mem_read", mem_read, 1'b0);
    step();                                    // cycle 1
    check("f.c1.mem_read", mem_read, 1'b1);
    check("f.c1.mem_write", mem_write, 1'b0);
    check("f.c1.mem_addr", mem_addr, 32'h40);
    check("f.c1.if_ack", if_ack, 1'b0);
    mem_ready = 1'b1;
    mem_rdata = 32'hE3A00001;
    step();                                    // cycle 2
    check("f.c2.if_ack", if_ack, 1'b1);
    check("f.c2.if_rdata", if_rdata, 32'hE3A00001);
    check("f.c2.mem_read", mem_read, 1'b0);
    check("f.c2.d_ack", d_ack, 1'b0);
    check("f.c2.bus_err", bus_err, 1'b0);
    if_req    = 1'b0;
    mem_ready = 1'b0;
    step();                                    // cycle 3
    check("f.c3.if_ack", if_ack, 1'b0);
    check("f.c3.if_rdata_hold", if_rdata, 32'hE3A00001);
    check("f.c3.d_ack", d_ack, 1'b0);

    // ---------------- data write, 3 wait cycles ----------------
    step();
    d_write = 1'b1;
    d_addr  = 32'h100;
    d_wdata = 32'hDEADBEEF;                    // cycle 0
    for (int c = 1; c <= 4; c++) begin
      step();
      check($sformatf("w.c%0d.mem_write", c), mem_write, 1'b1);
      check($sformatf("w.c%0d.mem_read", c), mem_read, 1'b0);
      check($sformatf("w.c%0d.mem_addr", c), mem_addr, 32'h100);
      check($sformatf("w.c%0d.mem_wdata", c), mem_wdata, 32'hDEADBEEF);
      check($sformatf("w.c%0d.d_ack", c), d_ack, 1'b0);
      if (c == 4) mem_ready = 1'b1;
    end
    step();                                    // cycle 5
    check("w.c5.d_ack", d_ack, 1'b1);
    check("w.c5.mem_write", mem_write, 1'b0);
    check("w.c5.d_rdata_unchanged", d_rdata, 32'h0);
    check("w.c5.if_ack", if_ack, 1'b0);
    check("w.c5.bus_err", bus_err, 1'b0);
    d_write   = 1'b0;
    mem_ready = 1'b0;
    step();
    check("w.c6.d_ack", d_ack, 1'b0);

    // ---------------- both requesting from reset, zero-wait ----------------
    reset = 1'b0;
    step();
    check_all_zero("rst2");
    reset     = 1'b1;
    if_req    = 1'b1;
    if_addr   = 32'h0000_0080;
    d_read    = 1'b1;
    d_addr    = 32'h0000_0300;
    mem_ready = 1'b1;                          // cycle 0
    mem_rdata = 32'hA000_0000;
    for (int c = 1; c <= 11; c++) begin
      step();
      mem_rdata = 32'hA000_0000 + 32'(c);
      // Grants in cycles 0,3,6,9 alternate data,fetch,data,fetch.
      check($sformatf("alt.c%0d.d_ack", c), d_ack, (c == 2 || c == 8) ? 1'b1 : 1'b0);
      check($sformatf("alt.c%0d.if_ack", c), if_ack, (c == 5 || c == 11) ? 1'b1 : 1'b0);
      check($sformatf("alt.c%0d.two_strobes", c), mem_read & mem_write, 1'b0);
      if (c == 1 || c == 7) begin
        check($sformatf("alt.c%0d.mem_addr", c), mem_addr, 32'h300);
        check($sformatf("alt.c%0d.mem_read", c), mem_read, 1'b1);
      end
      if (c == 4 || c == 10) begin
        check($sformatf("alt.c%0d.mem_addr", c), mem_addr, 32'h80);
        check($sformatf("alt.c%0d.mem_read", c), mem_read, 1'b1);
      end
      if (c == 2 || c == 8)
        check($sformatf("alt.c%0d.d_rdata", c), d_rdata, 32'hA000_0000 + 32'(c - 1));
      if (c == 5 || c == 11)
        check($sformatf("alt.c%0d.if_rdata", c), if_rdata, 32'hA000_0000 + 32'(c - 1));
      if (c == 11) begin
        if_req = 1'b0;
        d_read = 1'b0;
      end
    end
    exp_if_rdata = 32'hA000_000A;
    exp_d_rdata  = 32'hA000_0007;
    mem_ready = 1'b0;
    step();
    step();

    // ---------------- data read timeout ----------------
    d_read = 1'b1;
    d_addr = 32'h200;                          // cycle 0
    for (int c = 1; c <= 15; c++) begin
      step();
      check($sformatf("to.c%0d.mem_read", c), mem_read, 1'b1);
      check($sformatf("to.c%0d.d_ack", c), d_ack, 1'b0);
    end
    step();                                    // cycle 16
    check("to.c16.d_ack", d_ack, 1'b1);
    check("to.c16.bus_err", bus_err, 1'b1);
    check("to.c16.d_rdata", d_rdata, 32'h0);
    check("to.c16.mem_read", mem_read, 1'b0);
    check("to.c16.if_ack", if_ack, 1'b0);
    check("to.c16.if_rdata", if_rdata, exp_if_rdata);
    d_read = 1'b0;
    step();
    check("to.c17.bus_err", bus_err, 1'b0);
    check("to.c17.d_ack", d_ack, 1'b0);
    step();

    // ---------------- ready in the cycle the counter would expire ----------------
    d_read = 1'b1;
    d_addr = 32'h204;                          // cycle 0
    for (int c = 1; c <= 15; c++) begin
      step();
      if (c == 15) begin
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFEF00D;
      end
    end
    step();                                    // cycle 16
    check("race.c16.d_ack", d_ack, 1'b1);
    check("race.c16.bus_err", bus_err, 1'b0);
    check("race.c16.d_rdata", d_rdata, 32'hCAFEF00D);
    d_read    = 1'b0;
    mem_ready = 1'b0;
    step();
    step();

    // ---------------- reset during BUSY_D ----------------
    d_read = 1'b1;
    d_addr = 32'h208;                          // cycle 0
    step();                                    // cycle 1
    check("rbusy.c1.mem_read", mem_read, 1'b1);
    check("rbusy.c1.mem_addr", mem_addr, 32'h208);
    reset = 1'b0;
    step();                                    // cycle 2
    check_all_zero("rbusy.c2");
    reset   = 1'b1;
    d_read  = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h44;
    step();
    check("rbusy.fetch.mem_read", mem_read, 1'b1);
    check("rbusy.fetch.mem_addr", mem_addr, 32'h44);
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    step();
    check("rbusy.fetch.if_ack", if_ack, 1'b1);
    check("rbusy.fetch.if_rdata", if_rdata, 32'h1234_5678);
    if_req    = 1'b0;
    mem_ready = 1'b0;
    step();

    // ---------------- mem_ready while IDLE, no requests ----------------
    mem_ready = 1'b1;
    mem_rdata = 32'hBADBAD00;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("idle.c%0d.mem_read", c), mem_read, 1'b0);
      check($sformatf("idle.c%0d.mem_write", c), mem_write, 1'b0);
      check($sformatf("idle.c%0d.if_ack", c), if_ack, 1'b0);
      check($sformatf("idle.c%0d.d_ack", c), d_ack, 1'b0);
      check($sformatf("idle.c%0d.if_rdata", c), if_rdata, 32'h1234_5678);
      check($sformatf("idle.c%0d.d_rdata", c), d_rdata, 32'h0);
    end
    mem_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
